// File: rtl/rvseed_inst_loader_pkg.sv
// Shared constants and state encoding for the rvseed boot loader.
// Byte lanes per word and the loader FSM states live here so the core side can reuse them.
package rvseed_inst_loader_pkg;

  localparam int CPU_WIDTH          = 32;
  localparam int LDR_BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    LDR_ST_IDLE  = 2'd0,
    LDR_ST_RECV  = 2'd1,
    LDR_ST_WRITE = 2'd2,
    LDR_ST_RUN   = 2'd3
  } ldr_state_t;

endpackage

// File: rtl/rvseed_inst_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words written to IMEM from address 0.
// 4th byte at N -> im_we at N+1, done/cpu_rst_n at N+2 for the last word; byte_ready low outside RECV.
module rvseed_inst_loader
  import rvseed_inst_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = CPU_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_cnt,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [DATA_WIDTH-1:0] im_wdata,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [1:0]    LAST_LANE = 2'(LDR_BYTES_PER_WORD - 1);

  ldr_state_t            state, state_nxt;
  logic [CW-1:0]         count_q;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            byte_idx;
  logic [23:0]           asm_q;

  logic start_zero, start_big, start_ok;
  logic hs, last_word;
  logic done_nxt, err_set, load;

  assign start_zero = start && (word_cnt == '0);
  assign start_big  = start && (word_cnt > MAX_WORDS);
  assign start_ok   = start && !start_zero && !start_big;
  assign hs         = byte_valid && byte_ready;
  // count_q is one bit wider than word_idx, so a full-memory load still matches on 2**ADDR_WIDTH-1
  assign last_word  = ({1'b0, word_idx} == (count_q - 1'b1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= LDR_ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_set   = 1'b0;
    load      = 1'b0;
    case (state)
      LDR_ST_IDLE: begin
        if (start_zero) begin
          state_nxt = LDR_ST_RUN;
          done_nxt  = 1'b1;
        end else if (start_big) begin
          err_set = 1'b1;
        end else if (start_ok) begin
          load      = 1'b1;
          state_nxt = LDR_ST_RECV;
        end
      end
      LDR_ST_RECV: begin
        if (hs && (byte_idx == LAST_LANE)) state_nxt = LDR_ST_WRITE;
      end
      LDR_ST_WRITE: begin
        if (last_word) begin
          state_nxt = LDR_ST_RUN;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = LDR_ST_RECV;
        end
      end
      LDR_ST_RUN: begin
        if (start_big) begin
          err_set   = 1'b1;
          state_nxt = LDR_ST_IDLE;
        end else if (start_ok) begin
          load      = 1'b1;
          state_nxt = LDR_ST_RECV;
        end else if (start_zero) begin
          done_nxt = 1'b1;
        end
      end
      default: state_nxt = LDR_ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_ready <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_rst_n  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      count_q    <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      asm_q      <= '0;
    end else begin
      byte_ready <= (state_nxt == LDR_ST_RECV);
      im_we      <= (state_nxt == LDR_ST_WRITE);
      busy       <= (state_nxt == LDR_ST_RECV) || (state_nxt == LDR_ST_WRITE);
      cpu_rst_n  <= (state_nxt == LDR_ST_RUN);
      done       <= done_nxt;

      if (err_set)   err <= 1'b1;
      else if (load) err <= 1'b0;

      if (load) begin
        count_q  <= word_cnt;
        word_idx <= '0;
        byte_idx <= '0;
      end

      if (hs) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    asm_q[7:0]   <= byte_data;
          2'd1:    asm_q[15:8]  <= byte_data;
          2'd2:    asm_q[23:16] <= byte_data;
          default: begin
            im_wdata <= {byte_data, asm_q};
            im_addr  <= word_idx;
          end
        endcase
      end

      if ((state == LDR_ST_WRITE) && !last_word) word_idx <= word_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_rvseed_inst_loader.sv
// Directed bench for rvseed_inst_loader: full-rate and gappy loads, zero/oversize/full counts, reload and mid-load reset.
module tb_rvseed_inst_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n, start, byte_valid;
  logic [AW:0]   word_cnt;
  logic [7:0]    byte_data;
  logic          byte_ready, im_we, cpu_rst_n, busy, done, err;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  logic [7:0]    bq[$];
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  logic [AW-1:0] ea_q[$];
  logic [31:0]   ed_q[$];

  always #5 clk = ~clk;

  rvseed_inst_loader #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .word_cnt  (word_cnt),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wa_q.push_back(im_addr);
      wd_q.push_back(im_wdata);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start    = 1'b1;
    word_cnt = (AW+1)'(n);
    step();
    start    = 1'b0;
  endtask

  task automatic send(input bit gappy);
    int i = 0;
    int guard = 0;
    while (i < bq.size()) begin
      if (gappy && ($urandom_range(0, 1) == 0)) begin
        byte_valid = 1'b0;
      end else begin
        byte_valid = 1'b1;
        byte_data  = bq[i];
        if (byte_ready) i++;
      end
      step();
      guard++;
      if (guard > 4000) begin
        check("send_timeout", guard, 0);
        break;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic cmp_writes(input string tag);
    check({tag, "_nwr"}, wa_q.size(), ea_q.size());
    for (int k = 0; k < ea_q.size() && k < wa_q.size(); k++) begin
      check({tag, "_addr"}, 32'(wa_q[k]), 32'(ea_q[k]));
      check({tag, "_data"}, wd_q[k], ed_q[k]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; word_cnt = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (3) step();
    check("rst_ctl", {byte_ready, im_we, cpu_rst_n, busy, done, err}, 0);
    check("rst_addr", 32'(im_addr), 0);
    check("rst_wdata", im_wdata, 0);
    rst_n = 1'b1;
    step();

    // Two words at full rate
    wa_q.delete(); wd_q.delete();
    bq = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    do_start(2);
    check("t1_recv", {busy, byte_ready, cpu_rst_n}, 3'b110);
    send(1'b0);
    check("t1_we", {im_we, im_addr}, {1'b1, 8'h01});
    check("t1_wdata", im_wdata, 32'h0010_0093);
    check("t1_hold_rst", cpu_rst_n, 0);
    step();
    check("t1_done", {done, cpu_rst_n, busy}, 3'b110);
    step();
    check("t1_pulse", {done, cpu_rst_n}, 2'b01);
    ea_q = '{8'd0, 8'd1}; ed_q = '{32'h0000_0513, 32'h0010_0093};
    cmp_writes("t1");

    // Same load with gaps, issued from RUN
    wa_q.delete(); wd_q.delete();
    do_start(2);
    check("t2_rerst", {cpu_rst_n, busy}, 2'b01);
    send(1'b1);
    check("t2_we", im_we, 1);
    step();
    check("t2_done", {done, cpu_rst_n}, 2'b11);
    step();
    cmp_writes("t2");

    // Oversize count from RUN
    do_start(257);
    check("t3_err", {err, cpu_rst_n, byte_ready, busy}, 4'b1000);
    step();
    check("t3_idle", {err, cpu_rst_n, busy, done}, 4'b1000);

    // Zero count from IDLE
    wa_q.delete(); wd_q.delete();
    do_start(0);
    check("t4_done", {done, cpu_rst_n, im_we}, 3'b110);
    step();
    check("t4_run", {done, cpu_rst_n}, 2'b01);
    check("t4_nwr", wa_q.size(), 0);

    // Single-word reload from RUN clears err
    wa_q.delete(); wd_q.delete();
    do_start(1);
    check("t5_rerst", {cpu_rst_n, err, busy}, 3'b001);
    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    send(1'b0);
    step();
    check("t5_done", {done, cpu_rst_n}, 2'b11);
    step();
    ea_q = '{8'd0}; ed_q = '{32'h4433_2211};
    cmp_writes("t5");

    // Reset after 6 of 8 bytes
    wa_q.delete(); wd_q.delete();
    do_start(2);
    bq = '{8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee, 8'hff};
    send(1'b0);
    rst_n = 1'b0;
    step();
    check("t6_rst_ctl", {byte_ready, im_we, cpu_rst_n, busy, done, err}, 0);
    check("t6_rst_addr", 32'(im_addr), 0);
    check("t6_rst_wdata", im_wdata, 0);
    rst_n = 1'b1;
    repeat (5) step();
    check("t6_no_more_we", wa_q.size(), 1);
    check("t6_idle", {busy, byte_ready, cpu_rst_n}, 0);
    wa_q.delete(); wd_q.delete();
    do_start(1);
    bq = '{8'h01, 8'h02, 8'h03, 8'h04};
    send(1'b0);
    step();
    check("t6_done", {done, cpu_rst_n}, 2'b11);
    step();
    ea_q = '{8'd0}; ed_q = '{32'h0403_0201};
    cmp_writes("t6");

    // Full memory: word_cnt == 2**AW
    wa_q.delete(); wd_q.delete();
    bq.delete();
    for (int w = 0; w < (1 << AW); w++) begin
      for (int b = 0; b < 4; b++) bq.push_back(8'(w));
    end
    do_start(1 << AW);
    check("t7_start", {err, busy}, 2'b01);
    send(1'b0);
    check("t7_last_addr", 32'(im_addr), 32'hff);
    step();
    check("t7_done", {done, cpu_rst_n}, 2'b11);
    step();
    check("t7_nwr", wa_q.size(), 256);
    if (wa_q.size() == 256) begin
      check("t7_a255", 32'(wa_q[255]), 32'hff);
      check("t7_d255", wd_q[255], 32'hffff_ffff);
      check("t7_d128", wd_q[128], 32'h8080_8080);
      check("t7_a0", 32'(wa_q[0]), 0);
    end

    check("done_pulses", done_cnt, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rvseed_inst_loader.md
Name: rvseed_inst_loader

Overview:
- Boot/program loader sitting upstream of the rvseed instruction memory and core.
- Accepts a little-endian byte stream over a valid/ready handshake and assembles 32-bit instruction words.
- Writes the words sequentially into instruction memory from word address 0.
- Holds the core in reset while loading and releases it when the programmed word count has been written. This replaces file-based program loading with a synthesizable path.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width (depth = 2**ADDR_WIDTH words).
- DATA_WIDTH, `CPU_WIDTH (32), instruction word width; fixed at 32, 4 bytes per word.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  single-cycle request to begin a load.
- word_cnt  input  ADDR_WIDTH+1  number of words to load; sampled when start is accepted.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  stream byte; first byte of a word is bits [7:0].
- byte_ready  output  1  loader accepts a byte this cycle.
- im_we  output  1  instruction-memory write enable.
- im_addr  output  ADDR_WIDTH  instruction-memory word address.
- im_wdata  output  DATA_WIDTH  instruction-memory write data.
- cpu_rst_n  output  1  active-low reset to the core; low while not in RUN.
- busy  output  1  high in RECV and WRITE.
- done  output  1  one-cycle pulse on load completion.
- err  output  1  sticky: last start had word_cnt > 2**ADDR_WIDTH.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-low (rst_n sampled on the rising edge). All outputs are registered.
- Reset values: state=IDLE, byte_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_rst_n=0, busy=0, done=0, err=0. Internal counters are cleared.
- States: IDLE, RECV, WRITE, RUN.
- IDLE: core held in reset (cpu_rst_n=0).
  - On start with word_cnt==0: go to RUN, done=1 for one cycle.
  - On start with word_cnt > 2**ADDR_WIDTH: err=1, remain IDLE.
  - On any other start: latch word_cnt, clear word_idx and byte_idx, clear err, go to RECV.
- RECV: byte_ready=1, busy=1.
  - Each handshake (byte_valid & byte_ready) stores byte_data into lane byte_idx of the assembly register, then increments byte_idx (2 bits, wraps).
  - The 4th handshake moves to WRITE next cycle.
  - byte_valid low stalls indefinitely; no timeout.
- WRITE (exactly 1 cycle): im_we=1, im_addr=word_idx, im_wdata=assembled word, byte_ready=0.
  - If word_idx == count-1: go to RUN, done=1 in the first RUN cycle.
  - Otherwise: word_idx+1, return to RECV.
- RUN: cpu_rst_n=1, byte_ready=0.
  - start (valid word_cnt) re-enters RECV and drives cpu_rst_n=0 in the same transition; the core is re-reset before any write.
  - start with oversize word_cnt: err=1, go to IDLE (cpu_rst_n=0).
- Latency:
  - 4th accepted byte at cycle N gives im_we at N+1.
  - For the last word, done and cpu_rst_n=1 at N+2.
  - Minimum 5 cycles per word at full-rate input.
- start is ignored while busy; no error flag is raised.
- Bytes presented while byte_ready=0 are not consumed.
- word_cnt == 2**ADDR_WIDTH loads the full memory. word_idx never wraps, because the compare uses the ADDR_WIDTH+1-bit latched count.
- rst_n low mid-load:
  - Aborts the load next edge; all reset values apply.
  - Partially written memory contents are left as is.
  - A partial assembled word is discarded.
- im_wdata holds its last value when im_we=0.

Decomposition:
- rvseed_defines.v: CPU_WIDTH (existing); add LDR_ST_IDLE/RECV/WRITE/RUN 2-bit state encodings and LDR_BYTES_PER_WORD=4.
- Single module, no sub-module. The byte assembler is an inline 4-lane register with a 2-bit index.

Test Plan:
- Reset, start with word_cnt=2, stream 13 05 00 00 93 00 10 00 back-to-back:
  - im_we at addr 0 data 0x00000513, then addr 1 data 0x00100093.
  - done pulse; cpu_rst_n rises 2 cycles after the 8th handshake.
- Same load with byte_valid toggling 1-0-1 randomly: identical writes; no byte lost or duplicated.
- start with word_cnt=0: next cycle done=1, cpu_rst_n=1, no im_we.
- start with word_cnt=257 (ADDR_WIDTH=8): err=1, state IDLE, cpu_rst_n=0, byte_ready=0. A following start with word_cnt=1 clears err.
- In RUN, issue a second start with word_cnt=1:
  - cpu_rst_n drops the next cycle.
  - Word written to addr 0.
  - cpu_rst_n returns high after done.
- Mid-load (after 6 of 8 bytes), drive rst_n=0 for 1 cycle:
  - All outputs at reset values.
  - No further im_we.
  - A new start with word_cnt=1 writes addr 0 from fresh bytes.
